// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: quotient and remainder, optional two's-complement mode,
// ld/busy/done handshake and a divide-by-zero flag. One division in flight at a time.
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] qs;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] qs_nxt;

  // The most-negative operand maps onto 2**(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return (SIGNED && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                  input logic             neg);
    return neg ? -m : m;
  endfunction

  // One restoring step: the borrow out of the WIDTH+1 bit subtract selects restore.
  always_comb begin
    p_sh = {p[WIDTH-1:0], qs[WIDTH-1]};
    diff = p_sh - {1'b0, dv};
    if (!diff[WIDTH]) begin
      p_nxt  = diff;
      qs_nxt = {qs[WIDTH-2:0], 1'b1};
    end else begin
      p_nxt  = p_sh;
      qs_nxt = {qs[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      q     <= '0;
      r     <= '0;
      p     <= '0;
      qs    <= '0;
      dv    <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            if (b == '0) begin
              state <= FIN;
              done  <= 1'b1;
              dbz   <= 1'b1;
              q     <= '1;
              r     <= a;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dbz   <= 1'b0;
              p     <= '0;
              qs    <= magnitude(a);
              dv    <= magnitude(b);
              cnt   <= '0;
              neg_q <= SIGNED & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= SIGNED & a[WIDTH-1];
            end
          end
        end
        RUN: begin
          p   <= p_nxt;
          qs  <= qs_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= apply_sign(qs_nxt, neg_q);
            r     <= apply_sign(p_nxt[WIDTH-1:0], neg_r);
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: four instances (8u, 8s, 4s, 16s), each with its own driver,
// a FIFO scoreboard filled at issue time and a monitor that checks every done pulse.
module tb_seq_divider;

  typedef struct {
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          due;
    int          nbusy;
  } exp_t;

  typedef struct {
    int     w;
    bit     s;
    int     mode;
    longint a;
    longint b;
  } dir_t;

  // mode: 0 plain, 1 extra ld pulsed at edge k+3, 2 ld raised during FIN, 3 reset in cycle k+4
  localparam int ND = 20;
  dir_t dirs [ND] = '{
    '{8, 0, 1, 200, 7},   '{8, 0, 2, 5, 0},      '{8, 0, 0, 0, 9},
    '{8, 0, 3, 100, 3},   '{8, 0, 0, 9, 3},      '{8, 0, 0, 255, 1},
    '{8, 0, 2, 255, 255}, '{8, 0, 0, 1, 255},    '{8, 0, 2, 0, 0},
    '{8, 0, 1, 254, 127},
    '{8, 1, 0, -7, 2},    '{8, 1, 0, 7, -2},     '{8, 1, 0, -128, -1},
    '{8, 1, 1, -128, 1},  '{8, 1, 0, 127, -128}, '{8, 1, 2, -1, 0},
    '{8, 1, 0, -128, 0},  '{8, 1, 3, -128, -128},'{8, 1, 0, -128, -128},
    '{8, 1, 2, 5, -1}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fin = 0;

  function automatic void chk(input string nm, input longint act, input longint want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int          W     = (gi < 2) ? 8 : (gi == 2) ? 4 : 16;
    localparam bit          S     = (gi != 0);
    localparam logic [15:0] MASK  = 16'((32'd1 << W) - 1);
    localparam int          NRAND = (W == 4) ? 7500 : (W == 16) ? 2500 : 800;

    logic         rst, ld, busy, done, dbz;
    logic [W-1:0] a, b, q, r;
    exp_t         sbq[$];
    int           cyc = 0;
    bit           in_fin;

    seq_divider #(.WIDTH(W), .SIGNED(S)) dut (
      .clk(clk), .rst(rst), .ld(ld), .a(a), .b(b),
      .busy(busy), .done(done), .dbz(dbz), .q(q), .r(r)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input int k);
      exp_t   e;
      longint ai, bi, qi, ri;
      ai = longint'(av & MASK);
      bi = longint'(bv & MASK);
      if (S && av[W-1]) ai -= longint'(MASK) + 1;
      if (S && bv[W-1]) bi -= longint'(MASK) + 1;
      e.av = av & MASK;
      e.bv = bv & MASK;
      if (bi == 0) begin
        e.q = MASK; e.r = av & MASK; e.dbz = 1'b1; e.due = k; e.nbusy = 0;
      end else begin
        qi = ai / bi;
        ri = ai % bi;
        e.q = 16'(qi) & MASK; e.r = 16'(ri) & MASK; e.dbz = 1'b0;
        e.due = k + W; e.nbusy = W;
      end
      return e;
    endfunction

    function automatic logic [15:0] pick_op();
      logic [15:0] v;
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = S ? (MASK >> 1) : MASK;
        2:       v = S ? ((MASK >> 1) + 16'd1) : 16'd1;
        3:       v = 16'd1;
        4:       v = MASK;
        default: v = 16'($urandom);
      endcase
      return v & MASK;
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int mode_in);
      int mode, k, t;
      mode = mode_in;
      if ((bv & MASK) == '0 && (mode == 1 || mode == 3)) mode = 0;
      if (mode == 2 && in_fin) begin
        a = av[W-1:0]; b = bv[W-1:0]; ld = 1'b1;
        k = cyc + 2;
        sbq.push_back(model(av, bv, k));
        @(negedge clk);
        @(negedge clk);
        ld = 1'b0;
      end else begin
        if (in_fin) @(negedge clk);
        a = av[W-1:0]; b = bv[W-1:0]; ld = 1'b1;
        k = cyc + 1;
        sbq.push_back(model(av, bv, k));
        @(negedge clk);
        ld = 1'b0;
      end
      if (mode == 1) begin
        while (cyc < k + 2) @(negedge clk);
        a = W'($urandom); b = W'($urandom); ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
      end
      if (mode == 3) begin
        while (cyc < k + 3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk($sformatf("g%0d abort busy", gi), busy, 0);
        chk($sformatf("g%0d abort done", gi), done, 0);
        chk($sformatf("g%0d abort dbz", gi), dbz, 0);
        chk($sformatf("g%0d abort q", gi), q, 0);
        chk($sformatf("g%0d abort r", gi), r, 0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_fin = 1'b0;
        return;
      end
      t = 0;
      while (!done && t < W + 4) begin
        @(negedge clk);
        t++;
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL g%0d done_timeout a=%0h b=%0h: no done after %0d cycles", gi, av, bv, t);
        sbq.delete();
        in_fin = 1'b0;
      end else begin
        in_fin = 1'b1;
      end
    endtask

    initial begin
      rst = 1'b0; ld = 1'b0; a = '0; b = '0; in_fin = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("g%0d reset busy", gi), busy, 0);
      chk($sformatf("g%0d reset done", gi), done, 0);
      chk($sformatf("g%0d reset dbz", gi), dbz, 0);
      chk($sformatf("g%0d reset q", gi), q, 0);
      chk($sformatf("g%0d reset r", gi), r, 0);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < ND; i++)
        if (dirs[i].w == W && dirs[i].s == S)
          run_op(16'(dirs[i].a), 16'(dirs[i].b), dirs[i].mode);
      for (int n = 0; n < NRAND; n++) begin
        int m, mode;
        m = $urandom_range(0, 15);
        mode = (m < 3) ? m + 1 : 0;
        run_op(pick_op(), pick_op(), mode);
      end
      repeat (3) @(negedge clk);
      n_fin++;
    end

    initial begin
      int   bcnt;
      exp_t e;
      bcnt = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          bcnt = 0;
        end else begin
          if (busy) bcnt++;
          if (busy && done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL g%0d busy_done_overlap at cycle %0d: both high, expected exclusive", gi, cyc);
          end
          if (done) begin
            if (sbq.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL g%0d spurious_done at cycle %0d: done with no outstanding request", gi, cyc);
            end else begin
              e = sbq.pop_front();
              chk($sformatf("g%0d q a=%0h b=%0h", gi, e.av, e.bv), q, e.q);
              chk($sformatf("g%0d r a=%0h b=%0h", gi, e.av, e.bv), r, e.r);
              chk($sformatf("g%0d dbz a=%0h b=%0h", gi, e.av, e.bv), dbz, e.dbz);
              chk($sformatf("g%0d latency a=%0h b=%0h", gi, e.av, e.bv), cyc, e.due);
              chk($sformatf("g%0d busy_cycles a=%0h b=%0h", gi, e.av, e.bv), bcnt, e.nbusy);
            end
            bcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_fin < 4 && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (n_fin < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sim_timeout: %0d of 4 drivers finished, expected 4", n_fin);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
